triangle_raster_scheduler: RTL

//  Sequences one triangle_2d_fill instance over the screen-clamped bounding box of a tri_2d,
//  one candidate point per cycle. Tracks the fill pipeline latency and pushes covered pixels

---
 rtl/triangle_raster_scheduler.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/triangle_raster_scheduler.sv
// triangle_raster_scheduler: walks the screen-clamped bbox of a triangle through an external fill unit
// and queues covered pixels for the framebuffer writer; TRI_RASTER_CULL_EN adds a zero-area cull cycle.
module triangle_raster_scheduler #(
    parameter int SCREEN_W     = 1280,
    parameter int SCREEN_H     = 720,
    parameter int FILL_LATENCY = 3,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tri_valid,
    output logic                    tri_ready,
    input  logic [2:0][1:0][15:0]   tri_in,
    output logic [2:0][1:0][15:0]   fill_triangle,
    output logic [11:0]             fill_hcount,
    output logic [11:0]             fill_vcount,
    input  logic                    fill_is_within,
    output logic                    pix_valid,
    input  logic                    pix_ready,
    output logic [11:0]             pix_x,
    output logic [11:0]             pix_y,
    output logic                    busy,
    output logic                    done
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [15:0] XM = 16'(SCREEN_W - 1);
    localparam logic signed [15:0] YM = 16'(SCREEN_H - 1);
    typedef enum logic [2:0] {IDLE, BBOX, AREA, SCAN, DRAIN} state_t;
    state_t state;
    logic signed [15:0] vx [3];
    logic signed [15:0] vy [3];
    logic signed [15:0] rx0, rx1, ry0, ry1;
    logic [11:0] cx0, cx1, cy0, cy1, x0, x1, y1, sx, sy, fx0, fx1, fy0, fy1;
    logic empty_c, iss_v, push, pop, credit, drain_ok, skip;
    logic [FILL_LATENCY-1:0] pv;
    logic [11:0] px [FILL_LATENCY];
    logic [11:0] py [FILL_LATENCY];
    logic [11:0] mx [FIFO_DEPTH];
    logic [11:0] my [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0] cnt, cnt_nxt;

    function automatic logic [23:0] step(input logic [11:0] x, y, xa, xb);
        return x == xb ? {xa, y + 12'd1} : {x + 12'd1, y};
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            vx[k] = fill_triangle[k][0];
            vy[k] = fill_triangle[k][1];
        end
        rx0 = vx[0] < vx[1] ? vx[0] : vx[1];
        rx0 = vx[2] < rx0 ? vx[2] : rx0;
        rx1 = vx[0] > vx[1] ? vx[0] : vx[1];
        rx1 = vx[2] > rx1 ? vx[2] : rx1;
        ry0 = vy[0] < vy[1] ? vy[0] : vy[1];
        ry0 = vy[2] < ry0 ? vy[2] : ry0;
        ry1 = vy[0] > vy[1] ? vy[0] : vy[1];
        ry1 = vy[2] > ry1 ? vy[2] : ry1;
        empty_c = rx1 < 16'sd0 || rx0 > XM || ry1 < 16'sd0 || ry0 > YM;
        cx0 = rx0 < 16'sd0 ? 12'd0 : rx0[11:0];
        cx1 = rx1 > XM ? XM[11:0] : rx1[11:0];
        cy0 = ry0 < 16'sd0 ? 12'd0 : ry0[11:0];
        cy1 = ry1 > YM ? YM[11:0] : ry1[11:0];
        push = pv[FILL_LATENCY-1] & fill_is_within;
        pop = pix_valid & pix_ready;
        cnt_nxt = cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        // credit counts every point still able to land in the FIFO, so it can never overflow
        credit = int'(cnt) + $countones({pv, iss_v}) < FIFO_DEPTH;
        drain_ok = !iss_v && pv[FILL_LATENCY-2:0] == '0 && cnt_nxt == '0;
    end

`ifdef TRI_RASTER_CULL_EN
    localparam state_t ST = AREA;
    logic signed [16:0] abx, aby, acx, acy;
    logic signed [34:0] area;
    logic empty_r;
    logic [11:0] y0;
    always_comb begin
        abx = 17'(vx[1]) - 17'(vx[0]);
        aby = 17'(vy[1]) - 17'(vy[0]);
        acx = 17'(vx[2]) - 17'(vx[0]);
        acy = 17'(vy[2]) - 17'(vy[0]);
        area = 35'(abx) * 35'(acy) - 35'(aby) * 35'(acx);
    end
    assign skip = empty_r || area == '0;
    assign {fx0, fx1, fy0, fy1} = {x0, x1, y0, y1};
`else
    localparam state_t ST = BBOX;
    assign skip = empty_c;
    assign {fx0, fx1, fy0, fy1} = {cx0, cx1, cy0, cy1};
`endif

    assign tri_ready = state == IDLE;
    assign busy = state != IDLE;
    assign pix_valid = cnt != '0;
    assign pix_x = mx[rp];
    assign pix_y = my[rp];

    always_ff @(posedge clk) begin
        px[0] <= fill_hcount;
        py[0] <= fill_vcount;
        for (int i = 1; i < FILL_LATENCY; i++) begin
            px[i] <= px[i-1];
            py[i] <= py[i-1];
        end
        if (push) begin
            mx[wp] <= px[FILL_LATENCY-1];
            my[wp] <= py[FILL_LATENCY-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            fill_triangle <= '0;
            fill_hcount <= '0;
            fill_vcount <= '0;
            iss_v <= 1'b0;
            pv <= '0;
            done <= 1'b0;
            wp <= '0;
            rp <= '0;
            cnt <= '0;
        end else begin
            done <= 1'b0;
            iss_v <= 1'b0;
            pv <= {pv[FILL_LATENCY-2:0], iss_v};
            cnt <= cnt_nxt;
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            if (state == IDLE && tri_valid) begin
                fill_triangle <= tri_in;
                state <= BBOX;
            end
            if (state == BBOX) begin
                x0 <= cx0;
                x1 <= cx1;
                y1 <= cy1;
`ifdef TRI_RASTER_CULL_EN
                y0 <= cy0;
                empty_r <= empty_c;
                state <= AREA;
`endif
            end
            // first point is issued straight from the bbox, without waiting for credit
            if (state == ST) begin
                if (skip) state <= DRAIN;
                else begin
                    fill_hcount <= fx0;
                    fill_vcount <= fy0;
                    iss_v <= 1'b1;
                    {sx, sy} <= step(fx0, fy0, fx0, fx1);
                    state <= fx0 == fx1 && fy0 == fy1 ? DRAIN : SCAN;
                end
            end
            if (state == SCAN && credit) begin
                fill_hcount <= sx;
                fill_vcount <= sy;
                iss_v <= 1'b1;
                {sx, sy} <= step(sx, sy, x0, x1);
                if (sx == x1 && sy == y1) state <= DRAIN;
            end
            if (state == DRAIN && drain_ok) begin
                done <= 1'b1;
                state <= IDLE;
            end
        end
    end
endmodule
